reg_writeback_queue: RTL and testbench

//   Write-side producer for the CPU register bank: buffers completed results (rd, data) in a

---
 rtl/reg_writeback_queue.sv | 182 ++++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Buffers completed results (rd, data) in a small FIFO and drains them, at most
//   one per cycle, onto the register bank write port through a registered output
//   stage. It also keeps a per-register pending map and forwards the newest
//   pending value to two lookup ports, so decode never sees a stale register.
module reg_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_rd,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       wb_en,
   output logic                       reg_w_en,
   output logic [ADDR_W-1:0]          reg_w_addr,
   output logic [DATA_W-1:0]          reg_w_data,
   output logic [(1<<ADDR_W)-1:0]     pending,
   input  logic [ADDR_W-1:0]          lk_a_addr,
   output logic                       lk_a_hit,
   output logic [DATA_W-1:0]          lk_a_data,
   input  logic [ADDR_W-1:0]          lk_b_addr,
   output logic                       lk_b_hit,
   output logic [DATA_W-1:0]          lk_b_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int NREG  = 1 << ADDR_W;

   // FIFO control state
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic [DEPTH-1:0]  valid_q,  valid_d;

   // FIFO payload; validity is tracked separately so the payload needs no reset
   logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
   logic [DATA_W-1:0] ent_data_q [DEPTH];

   // Registered write-port stage
   logic              w_en_q,   w_en_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;

   logic push_fire;
   logic push_store;
   logic pop_fire;

   // A handshake to register 0 completes but nothing is stored for it.
   assign in_ready   = (count_q != CNT_W'(DEPTH));
   assign push_fire  = in_valid & in_ready;
   assign push_store = push_fire & (in_rd != '0);
   assign pop_fire   = wb_en & (count_q != '0);

   // Next-state for pointers, occupancy, valid map and the write-port stage
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;

      // Pop and push never touch the same slot: wr_ptr == rd_ptr only when
      // empty (no pop) or full (no push).
      if (pop_fire) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         w_en_d            = 1'b1;
         w_addr_d          = ent_rd_q[rd_ptr_q];
         w_data_d          = ent_data_q[rd_ptr_q];
      end
      if (push_store) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      case ({push_store, pop_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and output-stage registers, cleared asynchronously
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
      end
   end

   // Payload write on a stored push
   always_ff @(posedge clock) begin
      if (push_store) begin
         ent_rd_q[wr_ptr_q]   <= in_rd;
         ent_data_q[wr_ptr_q] <= in_data;
      end
   end

   assign reg_w_en   = w_en_q;
   assign reg_w_addr = w_addr_q;
   assign reg_w_data = w_data_q;
   assign count      = count_q;

   // Per-register pending bits: any valid entry or the output stage targeting r
   genvar gi;
   generate
      assign pending[0] = 1'b0;
      for (gi = 1; gi < NREG; gi++) begin : g_pend
         logic [DEPTH-1:0] ent_hit;
         // Match every FIFO slot against this register
         always_comb begin
            ent_hit = '0;
            for (int i = 0; i < DEPTH; i++) begin
               ent_hit[i] = valid_q[i] & (ent_rd_q[i] == ADDR_W'(gi));
            end
         end
         assign pending[gi] = (|ent_hit) | (w_en_q & (w_addr_q == ADDR_W'(gi)));
      end
   endgenerate

   // Forwarding ports: lookup 0 is A, lookup 1 is B
   logic [ADDR_W-1:0] lk_addr [2];
   logic              lk_hit  [2];
   logic [DATA_W-1:0] lk_data [2];

   assign lk_addr[0] = lk_a_addr;
   assign lk_addr[1] = lk_b_addr;
   assign lk_a_hit   = lk_hit[0];
   assign lk_a_data  = lk_data[0];
   assign lk_b_hit   = lk_hit[1];
   assign lk_b_data  = lk_data[1];

   generate
      for (gi = 0; gi < 2; gi++) begin : g_lk
         logic [PTR_W-1:0] idx;
         // Youngest match wins: start at the output stage (oldest), then walk
         // the FIFO from head towards tail so newer entries override.
         always_comb begin
            lk_hit[gi]  = 1'b0;
            lk_data[gi] = '0;
            idx         = '0;
            if (w_en_q && (w_addr_q == lk_addr[gi])) begin
               lk_hit[gi]  = 1'b1;
               lk_data[gi] = w_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
               idx = rd_ptr_q + PTR_W'(k);
               if (valid_q[idx] && (ent_rd_q[idx] == lk_addr[gi])) begin
                  lk_hit[gi]  = 1'b1;
                  lk_data[gi] = ent_data_q[idx];
               end
            end
            if (lk_addr[gi] == '0) begin
               lk_hit[gi]  = 1'b0;
               lk_data[gi] = '0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Testbench for reg_writeback_queue: directed scenarios followed by random
// traffic, all checked against a queue-based model of the write-back path.
module tb_reg_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic                    clock;
   logic                    reset_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [ADDR_W-1:0]       in_rd;
   logic [DATA_W-1:0]       in_data;
   logic                    wb_en;
   logic                    reg_w_en;
   logic [ADDR_W-1:0]       reg_w_addr;
   logic [DATA_W-1:0]       reg_w_data;
   logic [(1<<ADDR_W)-1:0]  pending;
   logic [ADDR_W-1:0]       lk_a_addr;
   logic                    lk_a_hit;
   logic [DATA_W-1:0]       lk_a_data;
   logic [ADDR_W-1:0]       lk_b_addr;
   logic                    lk_b_hit;
   logic [DATA_W-1:0]       lk_b_data;
   logic [CNT_W-1:0]        count;

   reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
      .wb_en(wb_en),
      .reg_w_en(reg_w_en), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
      .pending(pending),
      .lk_a_addr(lk_a_addr), .lk_a_hit(lk_a_hit), .lk_a_data(lk_a_data),
      .lk_b_addr(lk_b_addr), .lk_b_hit(lk_b_hit), .lk_b_data(lk_b_data),
      .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   // Reference model: queued results in acceptance order plus the write port
   ent_t              mq[$];
   logic              m_en;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   int                tests;
   int                fails;
   int                writes;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W:0] model_lookup(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].rd == a) return {1'b1, mq[i].data};
      if (m_en && m_addr == a) return {1'b1, m_data};
      return '0;
   endfunction

   function automatic logic [(1<<ADDR_W)-1:0] model_pending();
      logic [(1<<ADDR_W)-1:0] p;
      p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      if (m_en) p[m_addr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic check_all();
      logic [DATA_W:0] la, lb;
      la = model_lookup(lk_a_addr);
      lb = model_lookup(lk_b_addr);
      chk("count",     64'(count),      64'(mq.size()));
      chk("in_ready",  64'(in_ready),   64'(mq.size() != DEPTH));
      chk("reg_w_en",  64'(reg_w_en),   64'(m_en));
      chk("reg_w_addr",64'(reg_w_addr), 64'(m_addr));
      chk("reg_w_data",64'(reg_w_data), 64'(m_data));
      chk("pending",   64'(pending),    64'(model_pending()));
      chk("lk_a_hit",  64'(lk_a_hit),   64'(la[DATA_W]));
      chk("lk_a_data", 64'(lk_a_data),  64'(la[DATA_W-1:0]));
      chk("lk_b_hit",  64'(lk_b_hit),   64'(lb[DATA_W]));
      chk("lk_b_data", 64'(lk_b_data),  64'(lb[DATA_W-1:0]));
      chk("count_max", 64'(count <= DEPTH), 64'(1));
   endtask

   // One clock: decide the handshake from the pre-edge model, advance, check.
   task automatic step();
      bit   acc, pop;
      ent_t e;
      acc = in_valid && (mq.size() != DEPTH);
      pop = wb_en && (mq.size() != 0);
      @(posedge clock);
      if (pop) begin
         e      = mq.pop_front();
         m_en   = 1'b1;
         m_addr = e.rd;
         m_data = e.data;
         writes++;
      end else begin
         m_en = 1'b0;
      end
      if (acc && in_rd != 0) mq.push_back('{rd: in_rd, data: in_data});
      #1;
      check_all();
      $display("[TB] t=%0t in=%0b/%0b rd=%0d wb_en=%0b w_en=%0b addr=%0d data=%08h count=%0d",
               $time, in_valid, acc, in_rd, wb_en, reg_w_en, reg_w_addr, reg_w_data, count);
   endtask

   task automatic model_reset();
      mq.delete();
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   initial begin
      tests = 0; fails = 0; writes = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; wb_en = 1'b0;
      lk_a_addr = '0; lk_b_addr = '0;
      model_reset();
      #22;
      reset_n = 1'b1;
      #1;
      check_all();

      // Single write to r5 with the port available
      in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF; wb_en = 1'b1; lk_a_addr = 5'd5;
      step();
      chk("t2_pend5", 64'(pending[5]), 64'(1));
      chk("t2_hit",   64'(lk_a_hit),   64'(1));
      chk("t2_data",  64'(lk_a_data),  64'h DEADBEEF);
      in_valid = 1'b0;
      step();
      chk("t2_wen",   64'(reg_w_en),   64'(1));
      chk("t2_waddr", 64'(reg_w_addr), 64'(5));
      step();
      chk("t2_pend5_clr", 64'(pending[5]), 64'(0));

      // Fill to full with the port held, try a fifth push, then drain
      wb_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_rd = ADDR_W'(i); in_data = 32'h100 + 32'(i);
         step();
      end
      chk("t3_full_cnt",   64'(count),    64'(4));
      chk("t3_full_ready", 64'(in_ready), 64'(0));
      in_rd = 5'd9; in_data = 32'h999;
      step();
      chk("t3_stall_cnt", 64'(count), 64'(4));
      in_valid = 1'b0; wb_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t3_order", 64'(reg_w_addr), 64'(i));
         chk("t3_ready", 64'(in_ready),   64'(1));
      end
      step();

      // Two writes to r7: lookup must return the newer value
      wb_en = 1'b0; lk_b_addr = 5'd7;
      in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h11;
      step();
      in_data = 32'h22;
      step();
      in_valid = 1'b0;
      chk("t4_newest", 64'(lk_b_data), 64'h22);
      wb_en = 1'b1;
      step();
      chk("t4_after1", 64'(lk_b_data), 64'h22);
      wb_en = 1'b0;
      step();
      wb_en = 1'b1;
      step();
      chk("t4_pend_out", 64'(pending[7]), 64'(1));
      step();
      chk("t4_pend_clr", 64'(pending[7]), 64'(0));

      // Result for $zero: handshake completes, nothing is queued
      in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF; lk_a_addr = 5'd0;
      chk("t5_ready", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      chk("t5_cnt", 64'(count), 64'(0));
      step();
      chk("t5_wen",  64'(reg_w_en), 64'(0));
      chk("t5_miss", 64'(lk_a_hit), 64'(0));

      // Random traffic across wrap, full and empty boundaries
      for (int n = 0; n < 3 * DEPTH * 8; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_rd     = ADDR_W'($urandom_range(0, 7));
         in_data   = $urandom;
         wb_en     = ($urandom_range(0, 2) == 0);
         lk_a_addr = ADDR_W'($urandom_range(0, 7));
         lk_b_addr = ADDR_W'($urandom_range(0, 7));
         step();
      end

      // Reset in the middle of traffic discards everything immediately
      wb_en = 1'b0; in_valid = 1'b1; in_rd = 5'd3; in_data = 32'hABCD;
      step();
      step();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_all();

      // Random burst then a bounded drain
      for (int n = 0; n < 20; n++) begin
         in_valid = 1'b1; in_rd = ADDR_W'($urandom_range(1, 31)); in_data = $urandom;
         wb_en    = $urandom_range(0, 1) == 1;
         step();
      end
      in_valid = 1'b0; wb_en = 1'b1;
      for (int n = 0; n < 2 * DEPTH && count != 0; n++) step();
      chk("drain_done", 64'(count), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
